// File: rtl/scarv_rom_arbiter.sv
// Two-port arbiter in front of a single-port boot ROM with one cycle of read
// latency. Port 0 carries data/debug reads and port 1 carries instruction
// fetches. Returned words are not registered here: the ROM output is held by
// keeping rom_cen low while the owner stalls.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | no response outstanding
// ST_RESP0  | ROM word on rom_rdata belongs to port 0, rvalid high
// ST_RESP1  | ROM word on rom_rdata belongs to port 1, rvalid high
module scarv_rom_arbiter #(
   parameter int DEPTH    = 1024,
   parameter int WIDTH    = 32,
   parameter int ARB_MODE = 1,
   localparam int AW      = $clog2(DEPTH) - 1,
   localparam int DW      = WIDTH - 1
) (
   input  logic          g_clk,
   input  logic          g_reset,

   input  logic          r0_req,
   input  logic [AW:0]   r0_addr,
   output logic          r0_gnt,
   output logic          r0_rvalid,
   input  logic          r0_rready,
   output logic [DW:0]   r0_rdata,

   input  logic          r1_req,
   input  logic [AW:0]   r1_addr,
   output logic          r1_gnt,
   output logic          r1_rvalid,
   input  logic          r1_rready,
   output logic [DW:0]   r1_rdata,

   output logic          rom_cen,
   output logic [AW:0]   rom_addr,
   input  logic [DW:0]   rom_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RESP0 = 2'b01,
      ST_RESP1 = 2'b10
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_last;
   logic   w_last_nxt;

   logic   w_free;
   logic   w_pick1;
   logic   w_gnt0;
   logic   w_gnt1;

   // State and round-robin history; reset leaves port 1 as last served so
   // port 0 wins the first tie.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Issue permission, arbitration and next-state; grants never look at
   // rom_rdata so the ROM output has no path into the request side.
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_free      = 1'b0;
      w_pick1     = 1'b0;
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;

      // A response being consumed this cycle frees the ROM for a new read,
      // which is what allows one word per cycle when streaming.
      unique case (r_state)
         ST_IDLE:  w_free = 1'b1;
         ST_RESP0: w_free = r0_rready;
         ST_RESP1: w_free = r1_rready;
         default:  w_free = 1'b1;
      endcase

      // On a tie, round-robin hands the ROM to whichever port was not last.
      w_pick1 = (ARB_MODE != 0) && (r_last == 1'b0);

      if (!g_reset && w_free) begin
         if (r0_req && r1_req) begin
            w_gnt1 = w_pick1;
            w_gnt0 = !w_pick1;
         end else begin
            w_gnt0 = r0_req;
            w_gnt1 = r1_req;
         end
      end

      if (w_gnt0) begin
         w_state_nxt = ST_RESP0;
      end else if (w_gnt1) begin
         w_state_nxt = ST_RESP1;
      end else if (w_free) begin
         w_state_nxt = ST_IDLE;
      end

      if (ARB_MODE != 0) begin
         if (w_gnt0) begin
            w_last_nxt = 1'b0;
         end else if (w_gnt1) begin
            w_last_nxt = 1'b1;
         end
      end
   end

   // Output drive; rvalid is masked during reset because the state register
   // only clears on the reset edge.
   always_comb begin
      r0_gnt    = w_gnt0;
      r1_gnt    = w_gnt1;
      rom_cen   = w_gnt0 | w_gnt1;
      rom_addr  = w_gnt1 ? r1_addr : r0_addr;
      r0_rvalid = !g_reset && (r_state == ST_RESP0);
      r1_rvalid = !g_reset && (r_state == ST_RESP1);
      r0_rdata  = rom_rdata;
      r1_rdata  = rom_rdata;
   end

endmodule

// File: tb/tb_scarv_rom_arbiter.sv
// Bench for scarv_rom_arbiter: a round-robin instance (dut 0) and a fixed
// priority instance (dut 1) share stimulus, each with its own ROM model, and
// both are checked every cycle against a transaction-level reference.
module tb_scarv_rom_arbiter;

   localparam int DEPTH = 64;
   localparam int WIDTH = 32;
   localparam int AWB   = 6;

   typedef logic [74:0] vec_t;

   logic             g_clk = 1'b0;
   logic             g_reset;
   logic             r0_req, r1_req, r0_rready, r1_rready;
   logic [AWB-1:0]   r0_addr, r1_addr;

   logic             a_r0_gnt, a_r1_gnt, a_r0_rvalid, a_r1_rvalid, a_rom_cen;
   logic [WIDTH-1:0] a_r0_rdata, a_r1_rdata, a_rom_rdata;
   logic [AWB-1:0]   a_rom_addr;
   logic             b_r0_gnt, b_r1_gnt, b_r0_rvalid, b_r1_rvalid, b_rom_cen;
   logic [WIDTH-1:0] b_r0_rdata, b_r1_rdata, b_rom_rdata;
   logic [AWB-1:0]   b_rom_addr;

   logic [WIDTH-1:0] mem [DEPTH];

   // reference model: outstanding response, its owner, the word it must carry
   logic             m_pend [2];
   logic             m_own  [2];
   logic             m_last [2];
   logic [WIDTH-1:0] m_data [2];
   logic             eg0 [2];
   logic             eg1 [2];
   vec_t             obs [2];
   vec_t             exp_v [2];

   int n_vec = 0;
   int n_bad = 0;

   always #5 g_clk = ~g_clk;

   scarv_rom_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ARB_MODE(1)) u_rr (
      .g_clk(g_clk), .g_reset(g_reset),
      .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(a_r0_gnt),
      .r0_rvalid(a_r0_rvalid), .r0_rready(r0_rready), .r0_rdata(a_r0_rdata),
      .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(a_r1_gnt),
      .r1_rvalid(a_r1_rvalid), .r1_rready(r1_rready), .r1_rdata(a_r1_rdata),
      .rom_cen(a_rom_cen), .rom_addr(a_rom_addr), .rom_rdata(a_rom_rdata)
   );

   scarv_rom_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ARB_MODE(0)) u_fp (
      .g_clk(g_clk), .g_reset(g_reset),
      .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(b_r0_gnt),
      .r0_rvalid(b_r0_rvalid), .r0_rready(r0_rready), .r0_rdata(b_r0_rdata),
      .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(b_r1_gnt),
      .r1_rvalid(b_r1_rvalid), .r1_rready(r1_rready), .r1_rdata(b_r1_rdata),
      .rom_cen(b_rom_cen), .rom_addr(b_rom_addr), .rom_rdata(b_rom_rdata)
   );

   // synchronous ROMs, one cycle latency, output held while cen is low
   always @(posedge g_clk) if (a_rom_cen) a_rom_rdata <= mem[a_rom_addr];
   always @(posedge g_clk) if (b_rom_cen) b_rom_rdata <= mem[b_rom_addr];

   // Wait to the falling edge, capture both DUTs and compute what they should show.
   task automatic sample();
      @(negedge g_clk);
      obs[0] = {a_r0_gnt, a_r1_gnt, a_rom_cen, a_rom_addr, a_r0_rvalid, a_r1_rvalid,
                a_r0_rvalid ? a_r0_rdata : 32'h0, a_r1_rvalid ? a_r1_rdata : 32'h0};
      obs[1] = {b_r0_gnt, b_r1_gnt, b_rom_cen, b_rom_addr, b_r0_rvalid, b_r1_rvalid,
                b_r0_rvalid ? b_r0_rdata : 32'h0, b_r1_rvalid ? b_r1_rdata : 32'h0};
      for (int d = 0; d < 2; d++) begin
         logic can_issue, rv0, rv1;
         logic [AWB-1:0] ad;
         eg0[d] = 1'b0;
         eg1[d] = 1'b0;
         rv0 = 1'b0;
         rv1 = 1'b0;
         if (!g_reset) begin
            rv0 = m_pend[d] && !m_own[d];
            rv1 = m_pend[d] && m_own[d];
            can_issue = !m_pend[d] || (m_own[d] ? r1_rready : r0_rready);
            if (can_issue) begin
               if (r0_req && r1_req) begin
                  // dut 0 alternates, dut 1 always favours port 0
                  if (d == 0 && m_last[d] == 1'b0) eg1[d] = 1'b1;
                  else eg0[d] = 1'b1;
               end else begin
                  eg0[d] = r0_req;
                  eg1[d] = r1_req;
               end
            end
         end
         ad = eg1[d] ? r1_addr : r0_addr;
         exp_v[d] = {eg0[d], eg1[d], eg0[d] | eg1[d], ad, rv0, rv1,
                     rv0 ? m_data[d] : 32'h0, rv1 ? m_data[d] : 32'h0};
      end
   endtask

   // Rising edge: move the reference forward, then settle past the edge.
   task automatic advance();
      @(posedge g_clk);
      for (int d = 0; d < 2; d++) begin
         if (g_reset) begin
            m_pend[d] = 1'b0;
            m_own[d]  = 1'b0;
            m_last[d] = 1'b1;
         end else if (eg0[d] || eg1[d]) begin
            m_pend[d] = 1'b1;
            m_own[d]  = eg1[d];
            m_last[d] = eg1[d];
            m_data[d] = mem[eg1[d] ? r1_addr : r0_addr];
         end else if (m_pend[d] && (m_own[d] ? r1_rready : r0_rready)) begin
            m_pend[d] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      r0_req = 0; r1_req = 0; r0_rready = 1; r1_rready = 1;
      r0_addr = 0; r1_addr = 0; g_reset = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      g_reset = 1; r0_req = 1; r1_req = 1; r0_addr = 6'd11; r1_addr = 6'd22;
      for (int c = 0; c < 2; c++) begin
         sample();
         for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (obs[d] !== exp_v[d]) begin
               n_bad++;
               $display("FAIL reset dut%0d cyc%0d: got %h expected %h", d, c, obs[d], exp_v[d]);
            end
         end
         n_vec++;
         if ({a_r0_gnt, a_r1_gnt, a_rom_cen, a_r0_rvalid, a_r1_rvalid} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {a_r0_gnt, a_r1_gnt, a_rom_cen, a_r0_rvalid, a_r1_rvalid});
         end
         advance();
      end
      idle_inputs();
   endtask

   task automatic test_single();
      idle_inputs();
      r0_req = 1; r0_addr = 6'd5;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) r0_req = 0;
         sample();
         for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (obs[d] !== exp_v[d]) begin
               n_bad++;
               $display("FAIL single dut%0d cyc%0d: got %h expected %h", d, c, obs[d], exp_v[d]);
            end
         end
         n_vec++;
         if (c == 0 && !(a_r0_gnt === 1'b1 && a_rom_cen === 1'b1 && a_rom_addr === 6'd5)) begin
            n_bad++;
            $display("FAIL single_issue: gnt=%b cen=%b addr=%0d required 1 1 5", a_r0_gnt, a_rom_cen, a_rom_addr);
         end else if (c == 1 && !(a_r0_rvalid === 1'b1 && a_r0_rdata === mem[5])) begin
            n_bad++;
            $display("FAIL single_data: rvalid=%b rdata=%h required 1 %h", a_r0_rvalid, a_r0_rdata, mem[5]);
         end else if (c == 2 && a_r0_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: rvalid=%b required 0", a_r0_rvalid);
         end
         advance();
      end
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      for (int c = 0; c < 5; c++) begin
         r1_req  = (c < 4);
         r1_addr = 6'(c % 4);
         sample();
         for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (obs[d] !== exp_v[d]) begin
               n_bad++;
               $display("FAIL b2b dut%0d cyc%0d: got %h expected %h", d, c, obs[d], exp_v[d]);
            end
         end
         n_vec++;
         if (c > 0 && !(a_r1_rvalid === 1'b1 && a_r1_rdata === mem[c-1])) begin
            n_bad++;
            $display("FAIL b2b_stream cyc%0d: rvalid=%b rdata=%h required 1 %h", c, a_r1_rvalid, a_r1_rdata, mem[c-1]);
         end else if (c < 4 && a_r1_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_gnt cyc%0d: gnt=%b required 1", c, a_r1_gnt);
         end
         advance();
      end
   endtask

   task automatic test_contention();
      idle_inputs();
      g_reset = 1;
      sample();
      advance();
      g_reset = 0; r0_req = 1; r1_req = 1; r0_addr = 6'd10; r1_addr = 6'd20;
      for (int c = 0; c < 5; c++) begin
         if (c == 4) begin r0_req = 0; r1_req = 0; end
         sample();
         for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (obs[d] !== exp_v[d]) begin
               n_bad++;
               $display("FAIL contention dut%0d cyc%0d: got %h expected %h", d, c, obs[d], exp_v[d]);
            end
         end
         if (c < 4) begin
            n_vec++;
            if ({a_r0_gnt, a_r1_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
               n_bad++;
               $display("FAIL rr_order cyc%0d: gnt=%b required %b", c, {a_r0_gnt, a_r1_gnt},
                        (c % 2 == 0) ? 2'b10 : 2'b01);
            end
            n_vec++;
            if ({b_r0_gnt, b_r1_gnt} !== 2'b10) begin
               n_bad++;
               $display("FAIL fixed_prio cyc%0d: gnt=%b required 10", c, {b_r0_gnt, b_r1_gnt});
            end
         end
         advance();
      end
      sample();
      advance();
   endtask

   task automatic test_backpressure();
      idle_inputs();
      r0_req = 1; r0_addr = 6'd7; r0_rready = 0;
      for (int c = 0; c < 7; c++) begin
         if (c >= 1) begin r0_req = 0; r1_req = (c <= 4); r1_addr = 6'd9; end
         r0_rready = (c >= 4);
         sample();
         for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (obs[d] !== exp_v[d]) begin
               n_bad++;
               $display("FAIL backpressure dut%0d cyc%0d: got %h expected %h", d, c, obs[d], exp_v[d]);
            end
         end
         n_vec++;
         if (c >= 1 && c <= 3 && !(a_r0_rvalid === 1'b1 && a_r0_rdata === mem[7] &&
                                   a_rom_cen === 1'b0 && a_r1_gnt === 1'b0)) begin
            n_bad++;
            $display("FAIL bp_hold cyc%0d: rvalid=%b rdata=%h cen=%b gnt1=%b required 1 %h 0 0",
                     c, a_r0_rvalid, a_r0_rdata, a_rom_cen, a_r1_gnt, mem[7]);
         end else if (c == 4 && !(a_r1_gnt === 1'b1 && b_r1_gnt === 1'b1)) begin
            n_bad++;
            $display("FAIL bp_release: gnt1 rr=%b fp=%b required 1 1", a_r1_gnt, b_r1_gnt);
         end
         advance();
      end
   endtask

   task automatic test_handover();
      idle_inputs();
      r0_req = 1; r0_addr = 6'd3;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin r0_req = 0; r1_req = 1; r1_addr = 6'd12; end
         if (c == 2) r1_req = 0;
         sample();
         for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (obs[d] !== exp_v[d]) begin
               n_bad++;
               $display("FAIL handover dut%0d cyc%0d: got %h expected %h", d, c, obs[d], exp_v[d]);
            end
         end
         n_vec++;
         if (c == 1 && !(a_r0_rvalid === 1'b1 && a_r1_gnt === 1'b1)) begin
            n_bad++;
            $display("FAIL handover_issue: rvalid0=%b gnt1=%b required 1 1", a_r0_rvalid, a_r1_gnt);
         end else if (c == 2 && !(a_r0_rvalid === 1'b0 && a_r1_rvalid === 1'b1 && a_r1_rdata === mem[12])) begin
            n_bad++;
            $display("FAIL handover_swap: rvalid0=%b rvalid1=%b rdata=%h required 0 1 %h",
                     a_r0_rvalid, a_r1_rvalid, a_r1_rdata, mem[12]);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      r1_req = 1; r1_addr = 6'd30; r1_rready = 0;
      for (int c = 0; c < 6; c++) begin
         r0_req = 0; r1_req = 0; g_reset = 0;
         if (c == 0) r1_req = 1;
         if (c == 2) begin g_reset = 1; r0_req = 1; r1_req = 1; end
         if (c == 3) begin r0_req = 1; r1_req = 1; r0_addr = 6'd1; r1_addr = 6'd2; r1_rready = 1; end
         sample();
         for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (obs[d] !== exp_v[d]) begin
               n_bad++;
               $display("FAIL reset_mid dut%0d cyc%0d: got %h expected %h", d, c, obs[d], exp_v[d]);
            end
         end
         n_vec++;
         if (c == 1 && a_r1_rvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_pending: rvalid1=%b required 1", a_r1_rvalid);
         end else if (c == 2 && {a_r0_gnt, a_r1_gnt, a_r1_rvalid} !== 3'b000) begin
            n_bad++;
            $display("FAIL rm_during: gnt0 gnt1 rvalid1=%b required 000", {a_r0_gnt, a_r1_gnt, a_r1_rvalid});
         end else if (c == 3 && {a_r0_gnt, a_r1_gnt, a_r1_rvalid} !== 3'b100) begin
            n_bad++;
            $display("FAIL rm_after: gnt0 gnt1 rvalid1=%b required 100", {a_r0_gnt, a_r1_gnt, a_r1_rvalid});
         end
         advance();
      end
   endtask

   task automatic test_random();
      idle_inputs();
      for (int c = 0; c < 600; c++) begin
         // requests are held until granted by the round-robin instance
         if (!(r0_req && !eg0[0])) begin
            r0_req  = ($urandom_range(0, 2) != 0);
            r0_addr = 6'($urandom_range(0, DEPTH - 1));
         end
         if (!(r1_req && !eg1[0])) begin
            r1_req  = ($urandom_range(0, 2) != 0);
            r1_addr = 6'($urandom_range(0, DEPTH - 1));
         end
         r0_rready = ($urandom_range(0, 3) != 0);
         r1_rready = ($urandom_range(0, 3) != 0);
         g_reset   = ($urandom_range(0, 59) == 0);
         sample();
         for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (obs[d] !== exp_v[d]) begin
               n_bad++;
               $display("FAIL random dut%0d cyc%0d: got %h expected %h", d, c, obs[d], exp_v[d]);
            end
         end
         advance();
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      for (int d = 0; d < 2; d++) begin
         m_pend[d] = 0; m_own[d] = 0; m_last[d] = 1; m_data[d] = 0;
         eg0[d] = 0; eg1[d] = 0;
      end
      a_rom_rdata = 0;
      b_rom_rdata = 0;
      idle_inputs();
      g_reset = 1;
      @(posedge g_clk);
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_contention();
      test_backpressure();
      test_handover();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/scarv_rom_arbiter.md
Name: scarv_rom_arbiter

Overview:
- Shares one single-port, one-cycle-latency synchronous ROM between two requesters: port 0 (data/debug) and port 1 (instruction fetch).
- Accepts requests using req/gnt and drives the ROM enable and address.
- Returns each read word to its owner using rvalid/rready, holding it under backpressure.
- Sits between the CPU memory interfaces and the boot ROM instance.

Parameters:
- DEPTH, 1024: ROM depth in words. AW = $clog2(DEPTH)-1.
- WIDTH, 32: ROM word width. DW = WIDTH-1.
- ARB_MODE, 1: 0 = fixed priority (port 0 always wins); 1 = round-robin.

Ports:
- g_clk  in  1  clock; all state updates on the rising edge
- g_reset  in  1  synchronous, active-high reset
- r0_req  in  1  port 0 read request
- r0_addr  in  AW+1  port 0 word address
- r0_gnt  out  1  port 0 request accepted this cycle
- r0_rvalid  out  1  port 0 read data valid
- r0_rready  in  1  port 0 consumes read data
- r0_rdata  out  WIDTH  port 0 read data
- r1_req, r1_addr, r1_gnt, r1_rvalid, r1_rready, r1_rdata: same as port 0, for port 1
- rom_cen  out  1  ROM read enable
- rom_addr  out  AW+1  ROM word address
- rom_rdata  in  WIDTH  ROM read data; valid the cycle after rom_cen; stable while rom_cen=0

Behaviour:
- Single clock g_clk. g_reset is synchronous and active-high.
- State flops:
  - pend: a response is outstanding.
  - own: owner of the outstanding response (0 or 1).
  - last: last port served; round-robin only.
- Reset values:
  - pend=0, own=0, last=1, so port 0 wins the first tie.
  - While g_reset=1: r0_gnt=r1_gnt=0, rom_cen=0, r0_rvalid=r1_rvalid=0.
- Issue permission (combinational): free = !pend | (rX_rvalid & rX_rready) for the owning port X.
  - This allows back-to-back reads at one word per cycle.
- Arbitration, only when free=1:
  - Exactly one req asserted: that port is granted.
  - Both asserted, ARB_MODE=0: port 0 granted.
  - Both asserted, ARB_MODE=1: the port != last is granted.
- Grant outputs and ROM drive:
  - At most one gnt high per cycle.
  - rom_cen = r0_gnt | r1_gnt.
  - rom_addr = granted port's addr; r0_addr when no grant.
  - A handshake is req&gnt in the same cycle.
- On a grant to port G at edge t:
  - pend=1, own=G.
  - last=G (round-robin only).
- Response:
  - rX_rvalid = pend & (own==X).
  - r0_rdata = r1_rdata = rom_rdata, passed through unregistered.
  - Because rom_cen stays low while a response is stalled, rom_rdata remains the owner's word. No data register is needed.
- Read latency: the grant at cycle t gives rvalid from cycle t+1 until rready.
- Backpressure: while pend & !rready (owner), no grants are issued and rom_cen=0. Requests wait.
- Response accepted with no new grant: pend clears at the next edge.
- Response accepted with a new grant in the same cycle: pend stays 1 and own is updated to the new grantee.
  - If the new grantee is the other port, the old owner's rvalid drops and the new owner's rvalid rises at t+1.
- Requester protocol:
  - Hold req and addr stable until gnt.
  - req may be deasserted without a grant; nothing happens.
  - The block does not check either rule.
- rready while rvalid=0 is ignored.
- Reset mid-operation: a pending response is discarded. rvalid is 0 after the reset edge and no data is delivered.
- No combinational path from rom_rdata to any grant.
- gnt depends on req, rready and state only.

Test Plan:
- Single read, port 0: r0_addr=5, req held, rready=1. Expect r0_gnt=1 and rom_cen=1 with rom_addr=5 in cycle t; r0_rvalid=1 with r0_rdata=mem[5] in t+1; pend=0 at t+2.
- Back-to-back streaming, port 1: addr 0,1,2,3 with rready=1. Expect one gnt per cycle, rdata mem[0..3] in consecutive cycles, no bubbles.
- Contention, ARB_MODE=1: both req every cycle, addrs 10 and 20. Expect grants in the order 0,1,0,1. With ARB_MODE=0, port 0 gets every grant and r1_gnt=0 throughout.
- Backpressure: r0 granted addr 7, r0_rready=0 for 3 cycles, r1_req=1. Expect r0_rvalid=1 and r0_rdata=mem[7] held stable, rom_cen=0, r1_gnt=0. When rready rises, r1 is granted the same cycle.
- Handover: r0 response accepted while r1 is granted in the same cycle. Expect r0_rvalid=0 and r1_rvalid=1 at the next cycle.
- Reset mid-transfer: g_reset=1 for 1 cycle while r1_rvalid=1. Expect r1_rvalid=0, all gnt=0, and r0 winning the first subsequent tie.
